// File: rtl/smart_home_pkg.sv
// Shared types and constants for the smart-home controller and the sensor hub.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package smart_home_pkg;

  localparam int TEMP_W           = 7;
  localparam int ST_RESET_DEFAULT = 25;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HI,
    LO,
    DONE
  } temp_state_t;

endpackage

// File: rtl/smart_home_sensor_hub_debounce.sv
// One contact channel: 2-flop synchronizer followed by a stable-run debounce counter.
// Latency: output follows a settled input on edge DEB_CYCLES+2 after it is first sampled.
// Backpressure: none; free-running, output is a level.
module sensor_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic i_raw,
  output logic o_deb
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_out;
  logic [CW-1:0] r_cnt;

  // Synchronize the raw level, then flip the output only after a full run of disagreeing samples.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_out <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 != r_out) begin
        if (r_cnt == CW'(DEB_CYCLES - 1)) begin
          r_out <= r_s2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_deb = r_out;

endmodule

// File: rtl/smart_home_sensor_hub.sv
// Sensor front-end: debounces four contacts and periodically reads a serial temperature word.
// Latency: contacts DEB_CYCLES+2 edges; ST updates once per SAMPLE_PERIOD at the end of a frame.
// Backpressure: none; st_valid is a single-cycle pulse the controller must take when it fires.
// Optional macro SENSOR_HUB_TEMP_FILTER_EN: accept a reading only if it repeats the previous raw one.
module smart_home_sensor_hub
  import smart_home_pkg::*;
#(
  parameter int DEB_CYCLES    = 4,
  parameter int SCLK_DIV      = 2,
  parameter int SAMPLE_PERIOD = 64,
  parameter int ST_RESET      = ST_RESET_DEFAULT
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              raw_fd,
  input  logic              raw_rd,
  input  logic              raw_sw,
  input  logic              raw_fa,
  input  logic              temp_sdi,
  output logic              temp_csn,
  output logic              temp_sclk,
  output logic              SFD,
  output logic              SRD,
  output logic              SW,
  output logic              SFA,
  output logic [TEMP_W-1:0] ST,
  output logic              st_valid
);

  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BW = $clog2(TEMP_W + 1);

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_fd (.Clk(Clk), .Rst(Rst), .i_raw(raw_fd), .o_deb(SFD));
  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rd (.Clk(Clk), .Rst(Rst), .i_raw(raw_rd), .o_deb(SRD));
  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sw (.Clk(Clk), .Rst(Rst), .i_raw(raw_sw), .o_deb(SW));
  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_fa (.Clk(Clk), .Rst(Rst), .i_raw(raw_fa), .o_deb(SFA));

  temp_state_t       r_state;
  temp_state_t       w_next;
  logic [PW-1:0]     r_per;
  logic [DW-1:0]     r_div;
  logic [BW-1:0]     r_bits;
  logic [TEMP_W-1:0] r_shift;
  logic [TEMP_W-1:0] r_st;
  logic              r_st_valid;
  logic              w_wrap;
  logic              w_div_end;
  logic              w_all_bits;
  logic              w_take;
  logic              w_finish;
  logic              w_csn;
  logic              w_sclk;
`ifdef SENSOR_HUB_TEMP_FILTER_EN
  logic [TEMP_W-1:0] r_raw_last;
`endif

  assign w_wrap     = (r_per == PW'(SAMPLE_PERIOD - 1));
  assign w_div_end  = (r_div == DW'(SCLK_DIV - 1));
  assign w_all_bits = (r_bits == BW'(TEMP_W));
  // A bit is sampled on the edge that raises sclk: leaving SETUP, or leaving LO with bits still owed.
  assign w_take     = w_div_end && ((r_state == SETUP) || ((r_state == LO) && !w_all_bits));
  assign w_finish   = w_div_end && (r_state == LO) && w_all_bits;

  // State register for the temperature reader.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and pin decode; a period wrap outside IDLE is simply dropped.
  always_comb begin
    w_next = r_state;
    w_csn  = 1'b1;
    w_sclk = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_wrap) w_next = SETUP;
      end
      SETUP: begin
        w_csn = 1'b0;
        if (w_div_end) w_next = HI;
      end
      HI: begin
        w_csn  = 1'b0;
        w_sclk = 1'b1;
        if (w_div_end) w_next = LO;
      end
      LO: begin
        w_csn = 1'b0;
        if (w_div_end) w_next = w_all_bits ? DONE : HI;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Period counter, phase timer, shifter and the held ST word; ST moves only on frame completion.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_per      <= '0;
      r_div      <= '0;
      r_bits     <= '0;
      r_shift    <= '0;
      r_st       <= TEMP_W'(ST_RESET);
      r_st_valid <= 1'b0;
`ifdef SENSOR_HUB_TEMP_FILTER_EN
      r_raw_last <= TEMP_W'(ST_RESET);
`endif
    end else begin
      r_per      <= w_wrap ? '0 : r_per + 1'b1;
      r_st_valid <= 1'b0;

      if ((r_state == SETUP || r_state == HI || r_state == LO) && !w_div_end) begin
        r_div <= r_div + 1'b1;
      end else begin
        r_div <= '0;
      end

      if (r_state == IDLE) begin
        r_bits <= '0;
      end else if (w_take) begin
        r_shift <= {r_shift[TEMP_W-2:0], temp_sdi};
        r_bits  <= r_bits + 1'b1;
      end

      if (w_finish) begin
`ifdef SENSOR_HUB_TEMP_FILTER_EN
        r_raw_last <= r_shift;
        if (r_shift == r_raw_last) begin
          r_st       <= r_shift;
          r_st_valid <= 1'b1;
        end
`else
        r_st       <= r_shift;
        r_st_valid <= 1'b1;
`endif
      end
    end
  end

  assign temp_csn  = w_csn;
  assign temp_sclk = w_sclk;
  assign ST        = r_st;
  assign st_valid  = r_st_valid;

endmodule

// File: tb/tb_smart_home_sensor_hub.sv
// Bench for smart_home_sensor_hub: debounce table, temperature frames, mid-frame reset, random traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_smart_home_sensor_hub;

  localparam int DEB      = 4;
  localparam int ST_RST   = 25;
  localparam int FRAME_LO = 2 * (1 + 2 * 7);

  logic       Clk;
  logic       Rst;
  logic [3:0] raw;
  logic       temp_sdi;
  logic       temp_csn, temp_sclk, SFD, SRD, SW, SFA, st_valid;
  logic [6:0] ST;

  logic [3:0] raw2;
  logic       sdi2;
  logic       csn2, sclk2, vld2;
  logic [3:0] deb2;
  logic [6:0] ST2;

  smart_home_sensor_hub u_dut (
    .Clk(Clk), .Rst(Rst),
    .raw_fd(raw[3]), .raw_rd(raw[2]), .raw_sw(raw[1]), .raw_fa(raw[0]),
    .temp_sdi(temp_sdi), .temp_csn(temp_csn), .temp_sclk(temp_sclk),
    .SFD(SFD), .SRD(SRD), .SW(SW), .SFA(SFA), .ST(ST), .st_valid(st_valid)
  );

  smart_home_sensor_hub #(.SCLK_DIV(1), .SAMPLE_PERIOD(20)) u_dut2 (
    .Clk(Clk), .Rst(Rst),
    .raw_fd(raw2[3]), .raw_rd(raw2[2]), .raw_sw(raw2[1]), .raw_fa(raw2[0]),
    .temp_sdi(sdi2), .temp_csn(csn2), .temp_sclk(sclk2),
    .SFD(deb2[3]), .SRD(deb2[2]), .SW(deb2[1]), .SFA(deb2[0]), .ST(ST2), .st_valid(vld2)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // ---------------- sensor models ----------------
  logic [6:0] word_q[$];
  logic [6:0] frame_word = 7'd0;
  int         bit_i = 0;
  logic [6:0] word2 = 7'b1010101;
  int         bit2 = 0;

  always @(negedge temp_csn) begin
    if (word_q.size() > 0) frame_word = word_q.pop_front();
    else frame_word = 7'($urandom_range(0, 127));
    bit_i    = 6;
    temp_sdi = frame_word[6];
  end

  always @(negedge temp_sclk) begin
    if (!temp_csn && bit_i > 0) begin
      bit_i--;
      temp_sdi = frame_word[bit_i];
    end
  end

  always @(negedge csn2) begin
    bit2 = 6;
    sdi2 = word2[6];
  end

  always @(negedge sclk2) begin
    if (!csn2 && bit2 > 0) begin
      bit2--;
      sdi2 = word2[bit2];
    end
  end

  // ---------------- debounce reference ----------------
  // Output of a channel flips when the synchronized level has disagreed with it for the whole
  // last DEB edges, all of them after its previous flip (or reset).
  int         cyc = 0;
  logic       rst_q = 1'b0;
  logic [3:0] p1 = '0, p2 = '0;
  logic [3:0] s2h [0:63];
  logic [3:0] mdeb = '0;
  int         lastchg [4];

  always @(posedge Clk) begin
    cyc++;
    rst_q = Rst;
    if (Rst) begin
      p1   = '0;
      p2   = '0;
      mdeb = '0;
      for (int ch = 0; ch < 4; ch++) lastchg[ch] = cyc;
    end else begin
      s2h[cyc % 64] = p2;
      for (int ch = 0; ch < 4; ch++) begin
        if (cyc - lastchg[ch] >= DEB) begin
          logic all_diff;
          all_diff = 1'b1;
          for (int k = 0; k < DEB; k++)
            if (s2h[(cyc - k) % 64][ch] == mdeb[ch]) all_diff = 1'b0;
          if (all_diff) begin
            mdeb[ch]    = ~mdeb[ch];
            lastchg[ch] = cyc;
          end
        end
      end
      p2 = p1;
      p1 = raw;
    end
  end

  // ---------------- temperature reference / monitor ----------------
  logic prev_csn = 1'b1, prev_sclk = 1'b0;
  int   low_len = 0, pulses = 0;
  int   exp_st = ST_RST, prev_raw = ST_RST;
  int   n_frames = 0, n_pulses = 0, n_falls = 0, first_fall = 0;
  int   rel_cyc = 0;

  always @(negedge Clk) begin
    if (rst_q) begin
      check("rst_csn", temp_csn, 1);
      check("rst_sclk", temp_sclk, 0);
      check("rst_st", ST, ST_RST);
      check("rst_st_valid", st_valid, 0);
      exp_st   = ST_RST;
      prev_raw = ST_RST;
      low_len  = 0;
      pulses   = 0;
      n_falls  = 0;
    end else begin
      if (prev_csn && !temp_csn) begin
        if (n_falls == 0) first_fall = cyc;
        n_falls++;
      end
      if (!temp_csn) begin
        low_len++;
        if (temp_sclk && !prev_sclk) pulses++;
      end
      if (!prev_csn && temp_csn) begin
        logic exp_pulse;
        check("frame_csn_low_len", low_len, FRAME_LO);
        check("frame_sclk_pulses", pulses, 7);
`ifdef SENSOR_HUB_TEMP_FILTER_EN
        exp_pulse = (int'(frame_word) == prev_raw);
        prev_raw  = int'(frame_word);
`else
        exp_pulse = 1'b1;
`endif
        if (exp_pulse) exp_st = int'(frame_word);
        check("frame_st_valid", st_valid, int'(exp_pulse));
        n_frames++;
        if (st_valid) n_pulses++;
        low_len = 0;
        pulses  = 0;
      end else begin
        check("idle_st_valid", st_valid, 0);
      end
      check("st_hold", ST, exp_st);
    end
    check("debounce", {SFD, SRD, SW, SFA}, mdeb);
    prev_csn  = temp_csn;
    prev_sclk = temp_sclk;
  end

  // Second instance: fixed 1010101 word, one accepted reading every 20 cycles.
  int last2 = -1, n2 = 0;
  always @(negedge Clk) begin
    if (rst_q) begin
      last2 = -1;
    end else if (vld2) begin
      check("fast_st", ST2, 85);
      if (last2 >= 0) check("fast_spacing", cyc - last2, 20);
      else check("fast_first", cyc - rel_cyc, 35);
      last2 = cyc;
      n2++;
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [3:0] raw;
    int         hold;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl [14];
  logic rand_run = 1'b0;

  task automatic wait_falls(input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (n_falls > 0) break;
    end
    check(name, int'(n_falls > 0), 1);
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      if (n_frames >= target) break;
      @(negedge Clk);
    end
    check(name, int'(n_frames >= target), 1);
  endtask

  initial begin
    // {fd,rd,sw,fa}, cycles to hold, expected debounced outputs afterwards
    tbl[0]  = '{4'b0000, 10, 4'b0000};
    tbl[1]  = '{4'b1000,  5, 4'b0000};  // edge 5: not yet
    tbl[2]  = '{4'b1000,  1, 4'b1000};  // edge 6: SFD rises
    tbl[3]  = '{4'b0000,  6, 4'b0000};
    tbl[4]  = '{4'b1000,  3, 4'b0000};  // 3-cycle pulse ...
    tbl[5]  = '{4'b0000,  8, 4'b0000};  // ... rejected
    tbl[6]  = '{4'b1000,  4, 4'b0000};  // 4-cycle pulse ...
    tbl[7]  = '{4'b0000,  2, 4'b1000};  // ... just long enough
    tbl[8]  = '{4'b0000,  3, 4'b1000};
    tbl[9]  = '{4'b0000,  1, 4'b0000};
    tbl[10] = '{4'b0011,  5, 4'b0000};
    tbl[11] = '{4'b0011,  1, 4'b0011};  // SW and SFA on the same edge
    tbl[12] = '{4'b0100,  6, 4'b0100};
    tbl[13] = '{4'b0000,  6, 4'b0000};

    Rst  = 1'b1;
    raw  = '0;
    raw2 = '0;
    temp_sdi = 1'b0;
    sdi2 = 1'b0;
    word_q.push_back(7'd69);
    word_q.push_back(7'd70);
    word_q.push_back(7'd70);

    repeat (3) @(negedge Clk);
    Rst     = 1'b0;
    rel_cyc = cyc;

    for (int v = 0; v < 14; v++) begin
      raw = tbl[v].raw;
      repeat (tbl[v].hold) @(negedge Clk);
      check($sformatf("deb_vec%0d", v), {SFD, SRD, SW, SFA}, tbl[v].exp);
    end

    wait_falls("first_frame_seen");
    check("first_frame_start", first_fall - rel_cyc, 64);

    wait_frames(1, 200, "frame1_done");
`ifdef SENSOR_HUB_TEMP_FILTER_EN
    check("frame1_st", ST, ST_RST);
`else
    check("frame1_st", ST, 69);
`endif
    wait_frames(3, 300, "frame3_done");
    check("frame3_st", ST, 70);
`ifdef SENSOR_HUB_TEMP_FILTER_EN
    check("t5_pulses", n_pulses, 1);
`else
    check("t5_pulses", n_pulses, 3);
`endif

    // Reset three bits into a frame.
    begin
      int i;
      for (i = 0; i < 200; i++) begin
        @(negedge Clk);
        if (!temp_csn) break;
      end
      check("midrst_frame_seen", int'(!temp_csn), 1);
    end
    repeat (11) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    check("midrst_csn", temp_csn, 1);
    check("midrst_sclk", temp_sclk, 0);
    check("midrst_st", ST, ST_RST);
    check("midrst_st_valid", st_valid, 0);
    Rst     = 1'b0;
    rel_cyc = cyc;
    wait_falls("midrst_restart_seen");
    check("midrst_restart", first_fall - rel_cyc, 64);

    // Random contacts and random temperature words.
    begin
      int base;
      base = n_frames;
      rand_run = 1'b1;
      fork
        begin
          while (rand_run) begin
            raw = 4'($urandom);
            repeat ($urandom_range(1, 7)) @(negedge Clk);
          end
        end
        begin
          wait_frames(base + 8, 8 * 100, "random_frames_done");
          rand_run = 1'b0;
        end
      join
    end
    raw = '0;
    repeat (12) @(negedge Clk);
    check("final_debounce_idle", {SFD, SRD, SW, SFA}, 0);

    check("fast_pulse_count", int'(n2 >= 10), 1);
    check("fast_debounce_idle", deb2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
